sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 37 +++
 rtl/sdram_arb_if.sv | 29 ++
 rtl/sdram_arb_prio.sv | 33 +++
 rtl/sdram_arb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared codes and types for the SDRAM arbiter.
// Timeout support is selected with SDRAM_ARB_TIMEOUT_EN.
package sdram_arb_pkg;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'b00,
        OWN_CPU   = 2'b01,
        OWN_SPART = 2'b10,
        OWN_AUDIO = 2'b11
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [31:0] TIMEOUT_FILL    = 32'hDEAD_BEEF;
    localparam int unsigned TIMEOUT_CYC_DEF = 1023;

    typedef struct packed {
        owner_t      owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    // 2'b11 is reserved and behaves like OP_NONE
    function automatic logic op_valid(input logic [1:0] op);
        return (op != OP_NONE) && ((op == OP_READ) || (op == OP_WRITE));
    endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Backend memory bus between the arbiter and the SDRAM controller.
interface sdram_arb_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_a,
        output mem_wd,
        input  mem_rd,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_a,
        input  mem_wd,
        output mem_rd,
        output mem_ack
    );

endinterface

// File: rtl/sdram_arb_prio.sv
// Fixed-priority grant encoder: Audio > CPU > SPART.
module arb_prio
    import sdram_arb_pkg::*;
(
    input  logic   audio_req,
    input  logic   cpu_req,
    input  logic   spart_req,
    input  logic   mask_vld,
    input  owner_t mask_own,
    output owner_t grant
);

    logic a_ok;
    logic c_ok;
    logic s_ok;

    // the requester served last is ignored for one idle cycle
    assign a_ok = audio_req & ~(mask_vld & (mask_own == OWN_AUDIO));
    assign c_ok = cpu_req   & ~(mask_vld & (mask_own == OWN_CPU));
    assign s_ok = spart_req & ~(mask_vld & (mask_own == OWN_SPART));

    always_comb begin
        grant = OWN_IDLE;
        if (a_ok) begin
            grant = OWN_AUDIO;
        end else if (c_ok) begin
            grant = OWN_CPU;
        end else if (s_ok) begin
            grant = OWN_SPART;
        end
    end

endmodule

// File: rtl/sdram_arb.sv
// Three-way SDRAM arbiter (CPU, SPART, Audio) onto one backend port.
// Define SDRAM_ARB_TIMEOUT_EN to abort stuck ISSUE cycles.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic [1:0]  mem_op,
  input  logic [31:0] sdram_addr,
  input  logic [31:0] sdram_in,
  output logic [31:0] sdram_out,
  output logic [1:0]  mem_busy,

  input  logic        spart_req,
  input  logic        spart_we,
  input  logic [31:0] spart_addr,
  input  logic [31:0] spart_wdata,
  output logic [31:0] spart_rdata,
  output logic        spart_done,

  input  logic        audio_req,
  input  logic [31:0] audio_addr,
  output logic [31:0] audio_rdata,
  output logic        audio_done,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_ack,

  output logic        arb_err
);

  state_t      state_q;
  state_t      state_d;
  xfer_t       xfer_q;
  owner_t      grant;
  logic        mask_q;
  logic        cpu_req;
  logic        tmo;
  logic        fin;
  logic [31:0] rd_val;

  assign cpu_req = op_valid(mem_op);
  assign fin     = mem_ack | tmo;
  assign rd_val  = mem_ack ? mem_rd : TIMEOUT_FILL;

  arb_prio u_prio (
    .audio_req (audio_req),
    .cpu_req   (cpu_req),
    .spart_req (spart_req),
    .mask_vld  (mask_q),
    .mask_own  (xfer_q.owner),
    .grant     (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant != OWN_IDLE) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (fin) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_busy   = OWN_IDLE;
    spart_done = 1'b0;
    audio_done = 1'b0;
    unique case (state_q)
      ST_ISSUE: begin
        mem_req  = 1'b1;
        mem_we   = xfer_q.we;
        mem_busy = xfer_q.owner;
      end
      ST_DONE: begin
        mem_busy   = xfer_q.owner;
        spart_done = (xfer_q.owner == OWN_SPART);
        audio_done = (xfer_q.owner == OWN_AUDIO);
      end
      default: begin
      end
    endcase
  end

  assign mem_a  = xfer_q.addr;
  assign mem_wd = xfer_q.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_q <= '0;
      mask_q <= 1'b0;
    end else begin
      mask_q <= (state_q == ST_DONE);
      if (state_q == ST_IDLE) begin
        unique case (grant)
          OWN_AUDIO: xfer_q <= '{owner: OWN_AUDIO, we: 1'b0,
                                 addr: audio_addr, wdata: 32'h0};
          OWN_CPU:   xfer_q <= '{owner: OWN_CPU,
                                 we: (mem_op == OP_WRITE),
                                 addr: sdram_addr, wdata: sdram_in};
          OWN_SPART: xfer_q <= '{owner: OWN_SPART, we: spart_we,
                                 addr: spart_addr, wdata: spart_wdata};
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_out   <= 32'h0;
      spart_rdata <= 32'h0;
      audio_rdata <= 32'h0;
    end else if ((state_q == ST_ISSUE) && fin && !xfer_q.we) begin
      unique case (xfer_q.owner)
        OWN_CPU:   sdram_out   <= rd_val;
        OWN_SPART: spart_rdata <= rd_val;
        OWN_AUDIO: audio_rdata <= rd_val;
        default: begin
        end
      endcase
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_ISSUE) ? cnt_q + 1'b1 : '0;
      if (tmo && !mem_ack) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tmo = (state_q == ST_ISSUE) &&
               (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign arb_err = err_q;
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

endmodule
